fanout2: RTL and testbench

FANOUT2 -- requirements
Module: fanout2

---
 rtl/fanout2_if.sv | 25 ++
 rtl/fanout2.sv | 114 +++++++++++
 tb/tb_fanout2.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fanout2_if.sv
// fanout2_if: input FIFO read port plus two output FIFO write ports.
// master is the fanout2 side; slave is the FIFO / environment side.
interface fanout2_if #(
  parameter int DATA_SIZE = 32
);
  logic [DATA_SIZE-1:0] in_dout;
  logic                 in_empty;
  logic                 in_rd_en;
  logic [DATA_SIZE-1:0] out_a_din;
  logic                 out_a_full;
  logic                 out_a_wr_en;
  logic [DATA_SIZE-1:0] out_b_din;
  logic                 out_b_full;
  logic                 out_b_wr_en;

  modport master (
    input  in_dout, in_empty, out_a_full, out_b_full,
    output in_rd_en, out_a_din, out_a_wr_en, out_b_din, out_b_wr_en
  );

  modport slave (
    output in_dout, in_empty, out_a_full, out_b_full,
    input  in_rd_en, out_a_din, out_a_wr_en, out_b_din, out_b_wr_en
  );
endinterface

// File: rtl/fanout2.sv
// fanout2: copies each input FIFO sample to output FIFOs A and B, each side draining independently.
// Define FANOUT2_PIPELINE_EN to overlap the next read with the final write (1 sample per cycle).
module fanout2 #(
  parameter int DATA_SIZE = 32
) (
  input  logic      clock,
  input  logic      reset,
  fanout2_if.master bus
);

  typedef enum logic [1:0] {
    READ  = 2'b01,
    WRITE = 2'b10
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [DATA_SIZE-1:0] hold_r;
  logic [DATA_SIZE-1:0] hold_nxt_s;
  logic                 pend_a_r;
  logic                 pend_b_r;
  logic                 pend_a_nxt_s;
  logic                 pend_b_nxt_s;
  logic                 rd_en_s;
  logic                 a_wr_s;
  logic                 b_wr_s;
  logic [DATA_SIZE-1:0] a_din_s;
  logic [DATA_SIZE-1:0] b_din_s;

  // Next-state and strobe decode; strobes are forced low while reset is high.
  always_comb begin
    state_nxt_s  = state_r;
    hold_nxt_s   = hold_r;
    pend_a_nxt_s = pend_a_r;
    pend_b_nxt_s = pend_b_r;
    rd_en_s      = 1'b0;
    a_wr_s       = 1'b0;
    b_wr_s       = 1'b0;
    a_din_s      = {DATA_SIZE{1'b0}};
    b_din_s      = {DATA_SIZE{1'b0}};
    if (reset) begin
      state_nxt_s  = READ;
      pend_a_nxt_s = 1'b0;
      pend_b_nxt_s = 1'b0;
    end else begin
      case (state_r)
        READ: begin
          if (!bus.in_empty) begin
            rd_en_s      = 1'b1;
            hold_nxt_s   = bus.in_dout;
            pend_a_nxt_s = 1'b1;
            pend_b_nxt_s = 1'b1;
            state_nxt_s  = WRITE;
          end else begin
            state_nxt_s  = READ;
          end
        end
        WRITE: begin
          // Each side writes on its own; a full peer never stalls the other.
          a_wr_s       = pend_a_r & ~bus.out_a_full;
          b_wr_s       = pend_b_r & ~bus.out_b_full;
          a_din_s      = a_wr_s ? hold_r : {DATA_SIZE{1'b0}};
          b_din_s      = b_wr_s ? hold_r : {DATA_SIZE{1'b0}};
          pend_a_nxt_s = pend_a_r & ~a_wr_s;
          pend_b_nxt_s = pend_b_r & ~b_wr_s;
          if (pend_a_nxt_s | pend_b_nxt_s) begin
            state_nxt_s = WRITE;
          end else begin
`ifdef FANOUT2_PIPELINE_EN
            if (!bus.in_empty) begin
              rd_en_s      = 1'b1;
              hold_nxt_s   = bus.in_dout;
              pend_a_nxt_s = 1'b1;
              pend_b_nxt_s = 1'b1;
              state_nxt_s  = WRITE;
            end else begin
              state_nxt_s  = READ;
            end
`else
            state_nxt_s = READ;
`endif
          end
        end
        default: begin
          state_nxt_s  = READ;
          pend_a_nxt_s = 1'b0;
          pend_b_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State, hold register and pending flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= READ;
      hold_r   <= {DATA_SIZE{1'b0}};
      pend_a_r <= 1'b0;
      pend_b_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      hold_r   <= hold_nxt_s;
      pend_a_r <= pend_a_nxt_s;
      pend_b_r <= pend_b_nxt_s;
    end
  end

  assign bus.in_rd_en    = rd_en_s;
  assign bus.out_a_wr_en = a_wr_s;
  assign bus.out_a_din   = a_din_s;
  assign bus.out_b_wr_en = b_wr_s;
  assign bus.out_b_din   = b_din_s;

endmodule

// File: tb/tb_fanout2.sv
// tb_fanout2: directed vector table plus scoreboarded sequences for fanout2.
module tb_fanout2;
  logic clock;
  logic reset;
  int   passed;
  int   total;

  fanout2_if #(.DATA_SIZE(32)) bus ();

  fanout2 #(.DATA_SIZE(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        empty;
    logic [31:0] din;
    logic        af;
    logic        bf;
    logic [66:0] exp;
  } vec_t;

  vec_t vq[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(input logic rst, input logic empty, input logic [31:0] din,
                              input logic af, input logic bf, input logic rd,
                              input logic aw, input logic [31:0] ad,
                              input logic bw, input logic [31:0] bd);
    vec_t v;
    v.rst   = rst;
    v.empty = empty;
    v.din   = din;
    v.af    = af;
    v.bf    = bf;
    v.exp   = {rd, aw, ad, bw, bd};
    return v;
  endfunction

  function automatic logic [66:0] outs();
    return {bus.in_rd_en, bus.out_a_wr_en, bus.out_a_din, bus.out_b_wr_en, bus.out_b_din};
  endfunction

  task automatic check(input string name, input logic [66:0] got, input logic [66:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic drive(input logic rst, input logic empty, input logic [31:0] din,
                       input logic af, input logic bf);
    @(negedge clock);
    reset          = rst;
    bus.in_empty   = empty;
    bus.in_dout    = din;
    bus.out_a_full = af;
    bus.out_b_full = bf;
    #2;
  endtask

  initial begin
    logic [31:0] src[$];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] d;
    logic [9:0]  rd_pat;
    logic [9:0]  wr_pat;
    int          cyc;
    int          nxt;

    passed = 0;
    total  = 0;
    reset          = 1'b1;
    bus.in_empty   = 1'b1;
    bus.in_dout    = 32'h0;
    bus.out_a_full = 1'b0;
    bus.out_b_full = 1'b0;

    // rst empty din af bf | rd aw ad bw bd
    vq.push_back(mk(1'b1, 1'b0, 32'h0000AAAA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b0, 32'h00000005, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5, 1'b1, 32'h5));
    vq.push_back(mk(1'b0, 1'b0, 32'hFFFFFFFB, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFB, 1'b1, 32'hFFFFFFFB));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    // B full: A written one cycle after the read, no second read while B pends
    vq.push_back(mk(1'b0, 1'b0, 32'h00001234, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b0, 32'h00009999, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b0, 32'h00009999, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b0, 32'h00009999, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234));
    // alternating full flags
    vq.push_back(mk(1'b0, 1'b0, 32'h000000A1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA1));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA1, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b0, 32'h000000B2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'hB2, 1'b0, 32'h0));
    // completes B's pending B2, then reset while C3 is still pending on B
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB2));
    vq.push_back(mk(1'b0, 1'b0, 32'h000000C3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'hC3, 1'b0, 32'h0));
    vq.push_back(mk(1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b0, 32'h000000D4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hD4, 1'b1, 32'hD4));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].empty, vq[i].din, vq[i].af, vq[i].bf);
      check($sformatf("vec%0d", i), outs(), vq[i].exp);
    end

    // 100 random samples, full flags alternating every cycle
    for (int i = 0; i < 100; i++) begin
      d = $urandom;
      src.push_back(d);
      qa.push_back(d);
      qb.push_back(d);
    end
    cyc = 0;
    while ((qa.size() != 0 || qb.size() != 0) && cyc < 1000) begin
      drive(1'b0, (src.size() == 0), (src.size() == 0) ? 32'h0 : src[0], cyc[0], ~cyc[0]);
      if (bus.in_rd_en) begin
        if (src.size() == 0) check_bit("rd_while_empty", 1'b1, 1'b0);
        else void'(src.pop_front());
      end
      if (bus.out_a_wr_en) begin
        if (bus.out_a_full || qa.size() == 0) check_bit("a_wr_illegal", 1'b1, 1'b0);
        else check("rand_a", {35'h0, bus.out_a_din}, {35'h0, qa.pop_front()});
      end
      if (bus.out_b_wr_en) begin
        if (bus.out_b_full || qb.size() == 0) check_bit("b_wr_illegal", 1'b1, 1'b0);
        else check("rand_b", {35'h0, bus.out_b_din}, {35'h0, qb.pop_front()});
      end
      cyc++;
    end
    check_bit("rand_drained", (qa.size() == 0 && qb.size() == 0), 1'b1);
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    check("rand_idle", outs(), 67'h0);

    // continuous input, outputs never full: throughput pattern by mode
`ifdef FANOUT2_PIPELINE_EN
    rd_pat = 10'h0FF;
    wr_pat = 10'h1FE;
`else
    rd_pat = 10'h055;
    wr_pat = 10'h0AA;
`endif
    nxt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, (i >= 8), 32'h100 + nxt, 1'b0, 1'b0);
      check_bit($sformatf("rate_rd%0d", i), bus.in_rd_en, rd_pat[i]);
      check_bit($sformatf("rate_wa%0d", i), bus.out_a_wr_en, wr_pat[i]);
      check_bit($sformatf("rate_wb%0d", i), bus.out_b_wr_en, wr_pat[i]);
      if (bus.out_a_wr_en) begin
        if (qa.size() == 0) check_bit("rate_a_extra", 1'b1, 1'b0);
        else check("rate_a", {35'h0, bus.out_a_din}, {35'h0, qa.pop_front()});
      end
      if (bus.out_b_wr_en) begin
        if (qb.size() == 0) check_bit("rate_b_extra", 1'b1, 1'b0);
        else check("rate_b", {35'h0, bus.out_b_din}, {35'h0, qb.pop_front()});
      end
      if (bus.in_rd_en) begin
        qa.push_back(32'h100 + nxt);
        qb.push_back(32'h100 + nxt);
        nxt++;
      end
    end
    check_bit("rate_drained", (qa.size() == 0 && qb.size() == 0 && nxt == 4 + 4 * int'(rd_pat[1])), 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
